// File: rtl/spi_controller_mode.sv
// SPI controller: one full-duplex MSB-first transfer per start request, with
// run-time CPOL/CPHA, programmable half-period and one-hot-low peripheral select.
module spi_controller_mode #(
  parameter int unsigned SPI_DATA_WIDTH = 8,
  parameter int unsigned PERI_CNT       = 4,
  parameter int unsigned P_ADDR_WIDTH   = 2,
  parameter int unsigned DIV_WIDTH      = 8
) (
  input  logic                      sys_clk,
  input  logic                      sync_rst,
  input  logic                      sys_clk_en,
  input  logic                      start_txn,
  input  logic [SPI_DATA_WIDTH-1:0] tx_data,
  input  logic [P_ADDR_WIDTH-1:0]   p_addr,
  input  logic                      cpol,
  input  logic                      cpha,
  input  logic [DIV_WIDTH-1:0]      clk_div,
  output logic                      busy,
  output logic                      done,
  output logic [SPI_DATA_WIDTH-1:0] rx_data,
  input  logic                      cipo,
  output logic                      copi,
  output logic                      p_clk,
  output logic [PERI_CNT-1:0]       p_sel_n
);

  localparam int unsigned EdgeW = $clog2(2 * SPI_DATA_WIDTH + 1);
  // Edge count before the final p_clk edge of a transfer.
  localparam logic [EdgeW-1:0] LastM1 = EdgeW'(2 * SPI_DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StXfer, StHold} state_e;

  state_e                    state_q, state_d;
  logic [DIV_WIDTH-1:0]      div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0]      div_q, div_d;
  logic [EdgeW-1:0]          edge_q, edge_d;
  logic [SPI_DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [SPI_DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [SPI_DATA_WIDTH-1:0] rx_q, rx_d;
  logic                      done_q, done_d;
  logic                      copi_q, copi_d;
  logic                      pclk_q, pclk_d;
  logic [PERI_CNT-1:0]       sel_q, sel_d;
  logic                      cpol_q, cpol_d;
  logic                      cpha_q, cpha_d;

  logic accept;
  logic tick;
  logic edge_fire;

  assign accept = start_txn && (32'(p_addr) < PERI_CNT);
  assign tick   = (div_cnt_q == div_q);

  // State and datapath registers; reset wins over the clock enable.
  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      state_q   <= StIdle;
      div_cnt_q <= '0;
      div_q     <= '0;
      edge_q    <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_q      <= '0;
      done_q    <= 1'b0;
      copi_q    <= 1'b0;
      pclk_q    <= 1'b0;
      sel_q     <= '1;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
    end else if (sys_clk_en) begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_q      <= rx_d;
      done_q    <= done_d;
      copi_q    <= copi_d;
      pclk_q    <= pclk_d;
      sel_q     <= sel_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
    end
  end

  // Next-state: each phase ends when the half-period counter expires.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StSetup;
      StSetup: if (tick) state_d = StXfer;
      StXfer:  if (tick && (edge_q == LastM1 + 1'b1)) state_d = StHold;
      StHold:  if (tick) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values: latch on start, act on each p_clk edge, publish on exit.
  always_comb begin
    div_cnt_d = div_cnt_q;
    div_d     = div_q;
    edge_d    = edge_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_d      = rx_q;
    done_d    = 1'b0;
    copi_d    = copi_q;
    pclk_d    = pclk_q;
    sel_d     = sel_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    edge_fire = 1'b0;

    if (state_q != StIdle) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          div_cnt_d = '0;
          div_d     = clk_div;
          edge_d    = '0;
          tx_sh_d   = tx_data;
          rx_sh_d   = '0;
          copi_d    = tx_data[SPI_DATA_WIDTH-1];
          pclk_d    = cpol;
          cpol_d    = cpol;
          cpha_d    = cpha;
          for (int unsigned i = 0; i < PERI_CNT; i++) begin
            sel_d[i] = (32'(p_addr) != i);
          end
        end
      end
      StSetup: edge_fire = tick;
      StXfer:  edge_fire = tick && (edge_q != LastM1 + 1'b1);
      StHold: begin
        if (tick) begin
          done_d = 1'b1;
          rx_d   = rx_sh_q;
          sel_d  = '1;
          pclk_d = cpol_q;
        end
      end
      default: ;
    endcase

    // edge_q even means the edge now firing is a leading edge.
    if (edge_fire) begin
      edge_d = edge_q + 1'b1;
      pclk_d = ~pclk_q;
      if (!edge_q[0]) begin
        if (cpha_q) begin
          copi_d  = tx_sh_q[SPI_DATA_WIDTH-1];
          tx_sh_d = tx_sh_q << 1;
        end else begin
          rx_sh_d = {rx_sh_q[SPI_DATA_WIDTH-2:0], cipo};
        end
      end else begin
        if (cpha_q) begin
          rx_sh_d = {rx_sh_q[SPI_DATA_WIDTH-2:0], cipo};
        end else if (edge_q != LastM1) begin
          copi_d  = tx_sh_q[SPI_DATA_WIDTH-2];
          tx_sh_d = tx_sh_q << 1;
        end
      end
    end
  end

  // Outputs are straight from registers except busy, which decodes the state.
  always_comb begin
    busy    = (state_q != StIdle);
    done    = done_q;
    rx_data = rx_q;
    copi    = copi_q;
    p_clk   = pclk_q;
    p_sel_n = sel_q;
  end

endmodule

// File: tb/tb_spi_controller_mode.sv
// Self-checking bench for spi_controller_mode: directed mode/latency cases plus
// randomized transfers, compared every cycle against a transaction-level model.
module tb_spi_controller_mode;

  localparam int W    = 8;
  localparam int PERI = 4;
  localparam int PAW  = 3;
  localparam int DIVW = 8;

  logic           clk = 1'b0;
  logic           rst, en, start, cpol, cpha, loopback, cipo_drv;
  logic [W-1:0]   tx;
  logic [PAW-1:0] addr;
  logic [DIVW-1:0] div;
  logic           busy, done, copi, p_clk, cipo;
  logic [W-1:0]   rx_data;
  logic [PERI-1:0] p_sel_n;

  assign cipo = loopback ? copi : cipo_drv;

  always #5 clk = ~clk;

  spi_controller_mode #(
    .SPI_DATA_WIDTH(W), .PERI_CNT(PERI), .P_ADDR_WIDTH(PAW), .DIV_WIDTH(DIVW)
  ) dut (
    .sys_clk(clk), .sync_rst(rst), .sys_clk_en(en), .start_txn(start),
    .tx_data(tx), .p_addr(addr), .cpol(cpol), .cpha(cpha), .clk_div(div),
    .busy(busy), .done(done), .rx_data(rx_data), .cipo(cipo), .copi(copi),
    .p_clk(p_clk), .p_sel_n(p_sel_n)
  );

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a transfer lasts (2W+2)*H enabled cycles and
  // p_clk edge m (1..2W) happens H*m enabled cycles after the start.
  bit         m_active = 0, m_done = 0, m_cpol, m_cpha, m_loop;
  bit         m_idle_cpol = 0, m_copi_hold = 0;
  int         m_t, m_h = 1, m_addr;
  logic [W-1:0] m_tx, m_pat, m_rx = '0;
  logic [W-1:0] pat;

  function automatic int edges_done();
    int e;
    e = m_t / m_h;
    if (e > 2 * W) e = 2 * W;
    return e;
  endfunction

  function automatic logic exp_pclk();
    if (!m_active) return m_idle_cpol;
    return m_cpol ^ logic'(edges_done() % 2);
  endfunction

  function automatic logic exp_copi();
    int e, idx;
    if (!m_active) return m_copi_hold;
    e = edges_done();
    if (m_cpha) begin
      idx = (e + 1) / 2 - 1;
      if (idx < 0) idx = 0;
    end else begin
      idx = e / 2;
      if (idx > W - 1) idx = W - 1;
    end
    return m_tx[W-1-idx];
  endfunction

  function automatic logic [PERI-1:0] exp_sel();
    logic [PERI-1:0] s;
    s = '1;
    if (m_active) s[m_addr] = 1'b0;
    return s;
  endfunction

  task automatic model_update();
    if (rst) begin
      m_active = 0; m_done = 0; m_rx = '0; m_idle_cpol = 0; m_copi_hold = 0;
      return;
    end
    if (!en) return;
    m_done = 0;
    if (m_active) begin
      m_t++;
      if (m_t == (2 * W + 2) * m_h) begin
        m_active    = 0;
        m_done      = 1;
        m_rx        = m_loop ? m_tx : m_pat;
        m_copi_hold = m_tx[0];
      end
    end else if (start && int'(addr) < PERI) begin
      m_active = 1; m_t = 0; m_tx = tx; m_pat = pat; m_loop = loopback;
      m_cpol = cpol; m_cpha = cpha; m_idle_cpol = cpol; m_h = int'(div) + 1;
      m_addr = int'(addr);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_done));
      chk("p_sel_n", 32'(p_sel_n), 32'(exp_sel()));
      chk("p_clk", 32'(p_clk), 32'(exp_pclk()));
      chk("copi", 32'(copi), 32'(exp_copi()));
      chk("rx_data", 32'(rx_data), 32'(m_rx));
    end
  end

  bit en_rand = 0, noise = 0, pclk_prev = 0;
  int rises, sel2_cnt, busy_cnt, done_cnt;

  task automatic tick();
    int e, j;
    @(posedge clk);
    model_update();
    #1;
    if (p_clk && !pclk_prev) rises++;
    pclk_prev = p_clk;
    if (p_sel_n == 4'b1011) sel2_cnt++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (m_active) begin
      e = edges_done();
      j = m_cpha ? e / 2 : (e + 1) / 2;
      if (j > W - 1) j = W - 1;
      cipo_drv = m_pat[W-1-j];
    end else begin
      cipo_drv = 1'($urandom % 2);
    end
    en = en_rand ? 1'($urandom % 2) : 1'b1;
    if (noise) begin
      if (m_active) begin
        start = 1'($urandom % 2); tx = W'($urandom); addr = PAW'($urandom % 5);
        cpol = 1'($urandom % 2); cpha = 1'($urandom % 2); div = DIVW'($urandom % 4);
      end else begin
        start = 1'b0;
      end
    end
  endtask

  // Issue one start and, for a valid address, wait (bounded) for done while
  // counting enabled cycles from the start edge.
  task automatic run_txn(input logic [W-1:0] t_tx, input logic [W-1:0] t_pat,
                         input int t_addr, input bit t_cpol, input bit t_cpha,
                         input int t_div, input bit t_loop, output int lat);
    bit en_edge, got;
    tx = t_tx; pat = t_pat; addr = PAW'(t_addr); cpol = t_cpol; cpha = t_cpha;
    div = DIVW'(t_div); loopback = t_loop;
    en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    rises = 0;
    lat = 0;
    got = 0;
    if (t_addr < PERI) begin
      for (int n = 0; n < 5000 && !got; n++) begin
        en_edge = en;
        tick();
        if (en_edge) lat++;
        if (done) got = 1;
      end
      if (!got) chk("done_timeout", 32'd0, 32'd1);
    end
  endtask

  int lat;

  initial begin
    rst = 1; en = 1; start = 0; cpol = 0; cpha = 0; loopback = 0; cipo_drv = 0;
    tx = '0; addr = '0; div = '0; pat = '0;
    tick(); tick();
    rst = 0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_sel", 32'(p_sel_n), 32'hF);
    chk("reset_rx", 32'(rx_data), 32'd0);
    chk("reset_pclk", 32'(p_clk), 32'd0);
    chk("reset_copi", 32'(copi), 32'd0);
    chk_on = 1;
    tick();

    // Mode 0, divider 0, loopback.
    run_txn(8'hA5, 8'h00, 0, 0, 0, 0, 1, lat);
    chk("m0_lat", 32'(lat), 32'd18);
    chk("m0_rx", 32'(rx_data), 32'hA5);
    chk("m0_rises", 32'(rises), 32'd8);
    tick();

    // Mode 3, divider 3.
    run_txn(8'h3C, 8'hC3, 1, 1, 1, 3, 0, lat);
    chk("m3_lat", 32'(lat), 32'd72);
    chk("m3_rx", 32'(rx_data), 32'hC3);
    tick();
    chk("m3_idle_high", 32'(p_clk), 32'd1);

    // Modes 1 and 2 with a pattern that changes right after each sample edge.
    run_txn(8'h55, 8'h81, 3, 0, 1, 1, 0, lat);
    chk("m1_rx", 32'(rx_data), 32'h81);
    run_txn(8'hF0, 8'h81, 0, 1, 0, 2, 0, lat);
    chk("m2_rx", 32'(rx_data), 32'h81);
    tick();

    // Select index 2 held for the whole transfer; out-of-range index ignored.
    sel2_cnt = 0;
    run_txn(8'h12, 8'h34, 2, 0, 0, 0, 0, lat);
    chk("sel2_cycles", 32'(sel2_cnt), 32'd18);
    busy_cnt = 0; done_cnt = 0;
    run_txn(8'h77, 8'h00, 5, 0, 0, 0, 0, lat);
    for (int i = 0; i < 30; i++) tick();
    chk("bad_addr_busy", 32'(busy_cnt), 32'd0);
    chk("bad_addr_done", 32'(done_cnt), 32'd0);

    // Starts and input churn while busy, with the clock enable toggling.
    noise = 1; en_rand = 1;
    run_txn(8'h5A, 8'h96, 1, 0, 1, 1, 0, lat);
    noise = 0; en_rand = 0; start = 0;
    chk("busy_start_lat", 32'(lat), 32'd36);
    chk("busy_start_rx", 32'(rx_data), 32'h96);
    tick();

    // Reset on the 7th cycle of a transfer.
    tx = 8'hC7; pat = 8'h3E; addr = 3'd1; cpol = 1; cpha = 0; div = '0; loopback = 0;
    en = 1; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1;
    done_cnt = 0;
    tick();
    rst = 0;
    chk("rst_sel", 32'(p_sel_n), 32'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx", 32'(rx_data), 32'd0);
    for (int i = 0; i < 25; i++) tick();
    chk("rst_no_done", 32'(done_cnt), 32'd0);

    // Randomized transfers.
    for (int k = 0; k < 25; k++) begin
      int r_addr, r_div;
      r_addr = int'($urandom % 5);
      r_div  = int'($urandom % 4);
      en_rand = 1'($urandom % 2);
      noise   = 1'($urandom % 2);
      run_txn(W'($urandom), W'($urandom), r_addr, 1'($urandom % 2), 1'($urandom % 2),
              r_div, 1'($urandom % 4 == 0), lat);
      noise = 0; en_rand = 0; start = 0;
      if (r_addr < PERI) chk("rand_lat", 32'(lat), 32'((2 * W + 2) * (r_div + 1)));
      for (int i = 0; i < int'($urandom % 4); i++) tick();
    end

    tick();
    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
